// File: rtl/demod_readout_sequencer.sv
// Per-shot sequencer: arm, wait trigger edge, delay, forward one IQ point per window, count shots; optional DEMOD_SEQ_TIMESTAMP_EN adds ts_out.
// Latency: iq_valid_out one cycle after the captured sample; no backpressure, samples outside the window are dropped.
module demod_readout_sequencer #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 16,
  parameter int TMO_W = 16
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  input  logic [CNT_W-1:0] num_data_pts,
  input  logic [DLY_W-1:0] trig_delay,
  input  logic [TMO_W-1:0] shot_timeout,
  input  logic             iq_valid_in,
  input  logic [31:0]      i_val_in,
  input  logic [31:0]      q_val_in,
  output logic             iq_valid_out,
  output logic [31:0]      i_val_out,
  output logic [31:0]      q_val_out,
  output logic [CNT_W-1:0] shot_idx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             trig_overrun
`ifdef DEMOD_SEQ_TIMESTAMP_EN
  ,
  output logic [31:0]      ts_out
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_TRIG = 3'd1;
  localparam logic [2:0] DELAY     = 3'd2;
  localparam logic [2:0] WINDOW    = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [DLY_W-1:0] DLY_ONE = 1;
  localparam logic [TMO_W-1:0] TMO_ONE = 1;

  logic [2:0]       state;
  logic             trigQ;
  logic [CNT_W-1:0] numCfg;
  logic [DLY_W-1:0] dlyCfg;
  logic [TMO_W-1:0] tmoCfg;
  logic [DLY_W-1:0] dlyCnt;
  logic [TMO_W-1:0] tmoCnt;

  logic trigEdge;
  logic sampleTake;
  logic timeoutHit;
  logic shotClose;
  logic lastShot;

  assign trigEdge   = trigger & ~trigQ;
  assign sampleTake = (state == WINDOW) && iq_valid_in;
  // A sample arriving in the expiry cycle takes precedence over the timeout.
  assign timeoutHit = (state == WINDOW) && !iq_valid_in && (tmoCfg != '0) &&
                      (tmoCnt == tmoCfg - TMO_ONE);
  assign shotClose  = sampleTake || timeoutHit;
  assign lastShot   = (shot_idx == numCfg - CNT_ONE);
  assign busy       = (state != IDLE);

`ifdef DEMOD_SEQ_TIMESTAMP_EN
  logic [31:0] tsCnt;
  logic [31:0] tsLatch;

  always_ff @(posedge clk100) begin
    if (reset) begin
      tsCnt   <= '0;
      tsLatch <= '0;
      ts_out  <= '0;
    end else begin
      tsCnt <= tsCnt + 32'd1;
      if (!abort && state == WAIT_TRIG && trigEdge) tsLatch <= tsCnt;
      if (!abort && sampleTake) ts_out <= tsLatch;
    end
  end
`endif

  always_ff @(posedge clk100) begin
    if (reset) begin
      state        <= IDLE;
      trigQ        <= 1'b0;
      numCfg       <= '0;
      dlyCfg       <= '0;
      tmoCfg       <= '0;
      dlyCnt       <= '0;
      tmoCnt       <= '0;
      iq_valid_out <= 1'b0;
      i_val_out    <= '0;
      q_val_out    <= '0;
      shot_idx     <= '0;
      done         <= 1'b0;
      miss_cnt     <= '0;
      trig_overrun <= 1'b0;
    end else begin
      trigQ        <= trigger;
      iq_valid_out <= 1'b0;
      done         <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        if (trigEdge && (state == DELAY || state == WINDOW || state == DONE))
          trig_overrun <= 1'b1;
        case (state)
          IDLE: begin
            if (arm) begin
              numCfg       <= num_data_pts;
              dlyCfg       <= trig_delay;
              tmoCfg       <= shot_timeout;
              shot_idx     <= '0;
              miss_cnt     <= '0;
              trig_overrun <= 1'b0;
              if (num_data_pts == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= WAIT_TRIG;
              end
            end
          end
          WAIT_TRIG: begin
            if (trigEdge) begin
              dlyCnt <= '0;
              tmoCnt <= '0;
              state  <= (dlyCfg != '0) ? DELAY : WINDOW;
            end
          end
          DELAY: begin
            if (dlyCnt == dlyCfg - DLY_ONE) state <= WINDOW;
            else dlyCnt <= dlyCnt + DLY_ONE;
          end
          WINDOW: begin
            if (sampleTake) begin
              iq_valid_out <= 1'b1;
              i_val_out    <= i_val_in;
              q_val_out    <= q_val_in;
            end else if (timeoutHit) begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_ONE;
            end else begin
              tmoCnt <= tmoCnt + TMO_ONE;
            end
            if (shotClose) begin
              if (lastShot) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                shot_idx <= shot_idx + CNT_ONE;
                state    <= WAIT_TRIG;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demod_readout_sequencer.sv
// Directed bench for demod_readout_sequencer: shot timing, timeout, overrun, abort and zero-length runs.
module tb_demod_readout_sequencer;

  logic        clk100 = 1'b0;
  logic        reset, arm, abort, trigger, iq_valid_in;
  logic [15:0] num_data_pts, trig_delay, shot_timeout;
  logic [31:0] i_val_in, q_val_in;
  logic        iq_valid_out, busy, done, trig_overrun;
  logic [31:0] i_val_out, q_val_out;
  logic [15:0] shot_idx, miss_cnt;
`ifdef DEMOD_SEQ_TIMESTAMP_EN
  logic [31:0] ts_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk100 = ~clk100;

  demod_readout_sequencer dut (
    .clk100(clk100), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .num_data_pts(num_data_pts), .trig_delay(trig_delay), .shot_timeout(shot_timeout),
    .iq_valid_in(iq_valid_in), .i_val_in(i_val_in), .q_val_in(q_val_in),
    .iq_valid_out(iq_valid_out), .i_val_out(i_val_out), .q_val_out(q_val_out),
    .shot_idx(shot_idx), .busy(busy), .done(done), .miss_cnt(miss_cnt),
    .trig_overrun(trig_overrun)
`ifdef DEMOD_SEQ_TIMESTAMP_EN
    , .ts_out(ts_out)
`endif
  );

  task automatic cyc();
    @(posedge clk100);
    #1;
  endtask

  // Arms a run, then scrambles the config inputs: the run must use the latched values.
  task automatic arm_run(input logic [15:0] n, input logic [15:0] d, input logic [15:0] t);
    num_data_pts = n; trig_delay = d; shot_timeout = t; arm = 1'b1;
    cyc();
    arm = 1'b0; num_data_pts = 16'd7; trig_delay = 16'd9; shot_timeout = 16'd1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arm_busy: got %0b expected 1", busy); end
    checks++; if (shot_idx !== 16'd0) begin failures++; $display("FAIL arm_shot_idx: got %0d expected 0", shot_idx); end
  endtask

  // One shot with iq_valid_in held high from the trigger cycle; i/q change every cycle so the
  // captured value identifies the exact cycle the window opened (trigger cycle + d + 1).
  task automatic run_shot(input int d, input logic [31:0] ib, input logic [31:0] qb,
                          input logic last, input logic [15:0] idxAfter);
    trigger = 1'b1; iq_valid_in = 1'b1; i_val_in = ib; q_val_in = qb;
    for (int k = 1; k <= d + 1; k++) begin
      cyc();
      trigger = 1'b0;
      checks++; if (iq_valid_out !== 1'b0) begin failures++; $display("FAIL early_strobe k=%0d: got %0b expected 0", k, iq_valid_out); end
      i_val_in = ib + k; q_val_in = qb + k;
    end
    cyc();
    iq_valid_in = 1'b0;
    checks++; if (iq_valid_out !== 1'b1) begin failures++; $display("FAIL strobe: got %0b expected 1", iq_valid_out); end
    checks++; if (i_val_out !== ib + d + 1) begin failures++; $display("FAIL i_val_out: got %0h expected %0h", i_val_out, ib + d + 1); end
    checks++; if (q_val_out !== qb + d + 1) begin failures++; $display("FAIL q_val_out: got %0h expected %0h", q_val_out, qb + d + 1); end
    checks++; if (done !== last) begin failures++; $display("FAIL done_at_strobe: got %0b expected %0b", done, last); end
    checks++; if (shot_idx !== idxAfter) begin failures++; $display("FAIL shot_idx: got %0d expected %0d", shot_idx, idxAfter); end
    cyc();
    checks++; if (iq_valid_out !== 1'b0) begin failures++; $display("FAIL strobe_width: got %0b expected 0", iq_valid_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_width: got %0b expected 0", done); end
    checks++; if (busy !== !last) begin failures++; $display("FAIL busy_after_shot: got %0b expected %0b", busy, !last); end
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; iq_valid_in = 1'b0;
    num_data_pts = '0; trig_delay = '0; shot_timeout = '0; i_val_in = '0; q_val_in = '0;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (iq_valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", iq_valid_out); end
    checks++; if (i_val_out !== 32'd0 || q_val_out !== 32'd0) begin failures++; $display("FAIL rst_iq: got %0h/%0h expected 0/0", i_val_out, q_val_out); end
    checks++; if (shot_idx !== 16'd0 || miss_cnt !== 16'd0) begin failures++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", shot_idx, miss_cnt); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || trig_overrun !== 1'b0) begin failures++; $display("FAIL rst_flags: got %0b%0b%0b expected 000", busy, done, trig_overrun); end
  endtask

  task automatic test_three_shots();
    arm_run(16'd3, 16'd4, 16'd0);
    run_shot(4, 32'd100, 32'd200, 1'b0, 16'd1);
    run_shot(4, 32'd300, 32'd400, 1'b0, 16'd2);
    run_shot(4, 32'd500, 32'd600, 1'b1, 16'd2);
  endtask

  task automatic test_zero_delay();
    arm_run(16'd1, 16'd0, 16'd0);
    run_shot(0, 32'hFFFF_FFFA, 32'd6, 1'b1, 16'd0);
    checks++; if ($signed(i_val_out) !== -32'sd5 || q_val_out !== 32'd7) begin failures++; $display("FAIL zero_delay_iq: got %0d/%0d expected -5/7", $signed(i_val_out), q_val_out); end
  endtask

  task automatic test_timeout_miss();
    arm_run(16'd2, 16'd2, 16'd10);
    trigger = 1'b1; iq_valid_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      trigger = 1'b0;
      checks++; if (iq_valid_out !== 1'b0 || miss_cnt !== 16'd0 || shot_idx !== 16'd0) begin
        failures++; $display("FAIL tmo_open k=%0d: got v=%0b miss=%0d idx=%0d expected 0/0/0", k, iq_valid_out, miss_cnt, shot_idx); end
    end
    cyc();
    checks++; if (miss_cnt !== 16'd1 || shot_idx !== 16'd1 || iq_valid_out !== 1'b0) begin
      failures++; $display("FAIL tmo_close: got miss=%0d idx=%0d v=%0b expected 1/1/0", miss_cnt, shot_idx, iq_valid_out); end
    run_shot(2, 32'd10, 32'd20, 1'b1, 16'd1);
    checks++; if (miss_cnt !== 16'd1) begin failures++; $display("FAIL tmo_miss_final: got %0d expected 1", miss_cnt); end
  endtask

  task automatic test_sample_vs_timeout();
    arm_run(16'd1, 16'd1, 16'd3);
    trigger = 1'b1; iq_valid_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      trigger = 1'b0;
      checks++; if (iq_valid_out !== 1'b0) begin failures++; $display("FAIL tie_early k=%0d: got %0b expected 0", k, iq_valid_out); end
    end
    iq_valid_in = 1'b1; i_val_in = 32'h1234; q_val_in = 32'h5678;
    cyc();
    iq_valid_in = 1'b0;
    checks++; if (iq_valid_out !== 1'b1 || i_val_out !== 32'h1234 || q_val_out !== 32'h5678) begin
      failures++; $display("FAIL tie_strobe: got v=%0b i=%0h q=%0h expected 1/1234/5678", iq_valid_out, i_val_out, q_val_out); end
    checks++; if (miss_cnt !== 16'd0 || done !== 1'b1) begin failures++; $display("FAIL tie_miss_done: got %0d/%0b expected 0/1", miss_cnt, done); end
    cyc();
  endtask

  task automatic test_overrun();
    arm_run(16'd1, 16'd4, 16'd0);
    trigger = 1'b1;
    cyc(); trigger = 1'b0;
    checks++; if (trig_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clean: got %0b expected 0", trig_overrun); end
    cyc(); trigger = 1'b1;
    cyc(); trigger = 1'b0;
    checks++; if (trig_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %0b expected 1", trig_overrun); end
    cyc();
    cyc(); iq_valid_in = 1'b1; i_val_in = 32'd77; q_val_in = 32'd88;
    cyc(); iq_valid_in = 1'b0;
    checks++; if (iq_valid_out !== 1'b1 || i_val_out !== 32'd77 || done !== 1'b1 || shot_idx !== 16'd0) begin
      failures++; $display("FAIL ovr_shot: got v=%0b i=%0d done=%0b idx=%0d expected 1/77/1/0", iq_valid_out, i_val_out, done, shot_idx); end
    cyc();
    checks++; if (busy !== 1'b0 || trig_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got busy=%0b ovr=%0b expected 0/1", busy, trig_overrun); end
  endtask

  task automatic test_abort_rearm();
    arm_run(16'd2, 16'd0, 16'd0);
    checks++; if (trig_overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared: got %0b expected 0", trig_overrun); end
    trigger = 1'b1;
    cyc(); trigger = 1'b0; abort = 1'b1; iq_valid_in = 1'b1; i_val_in = 32'd999; q_val_in = 32'd999;
    cyc(); abort = 1'b0;
    checks++; if (busy !== 1'b0 || iq_valid_out !== 1'b0 || i_val_out !== 32'd77) begin
      failures++; $display("FAIL abort: got busy=%0b v=%0b i=%0d expected 0/0/77", busy, iq_valid_out, i_val_out); end
    num_data_pts = 16'd2; trig_delay = 16'd0; shot_timeout = 16'd0; arm = 1'b1; i_val_in = 32'd555;
    cyc(); arm = 1'b0; iq_valid_in = 1'b0;
    checks++; if (busy !== 1'b1 || iq_valid_out !== 1'b0 || i_val_out !== 32'd77 || shot_idx !== 16'd0) begin
      failures++; $display("FAIL rearm: got busy=%0b v=%0b i=%0d idx=%0d expected 1/0/77/0", busy, iq_valid_out, i_val_out, shot_idx); end
    run_shot(0, 32'd40, 32'd50, 1'b0, 16'd1);
    run_shot(0, 32'd60, 32'd70, 1'b1, 16'd1);
    num_data_pts = 16'd0; arm = 1'b1;
    cyc(); arm = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b1 || shot_idx !== 16'd0) begin
      failures++; $display("FAIL zero_pts_done: got done=%0b busy=%0b idx=%0d expected 1/1/0", done, busy, shot_idx); end
    cyc();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_pts_idle: got done=%0b busy=%0b expected 0/0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_three_shots();
    test_zero_delay();
    test_timeout_miss();
    test_sample_vs_timeout();
    test_overrun();
    test_abort_rearm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
